// File: rtl/cpu_iob_bridge.sv
// Purpose: bridge the CPU data-memory port onto an IOb native-bus manager, one bus access per distinct CPU access.
// Latency: valid rises 1 cycle after the request; read data lands in ReadData on the edge where ready is seen.
// Backpressure: holds valid/addr/wdata/wstrb stable in REQ until ready; the CPU side is not stalled by this block.
module cpu_iob_bridge #(
   parameter int FE_ADDR_W = 32,
   parameter int FE_DATA_W = 32   // must be 32: data paths connect straight to the 32-bit CPU port
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iob_ready_i,
   input  logic [FE_DATA_W-1:0]   iob_rdata_i,
   output logic                   iob_valid_o,
   output logic [FE_ADDR_W-1:0]   iob_addr_o,
   output logic [FE_DATA_W-1:0]   iob_wdata_o,
   output logic [FE_DATA_W/8-1:0] iob_wstrb_o,
   input  logic                   MemWrite,
   input  logic [31:0]            WriteData,
   input  logic [31:0]            DataAdr,
   output logic [31:0]            ReadData
);

   localparam int STRB_W = FE_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t              state, state_d;
   logic                valid_q, valid_d;
   logic [FE_ADDR_W-1:0] addr_q, addr_d;
   logic [FE_DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                wr_q, wr_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                 req;
   logic                 launch;
   logic [FE_ADDR_W-1:0] adr_ext;

   // CPU address resized to the bus address width (zero-extend or truncate)
   generate
      if (FE_ADDR_W > 32) begin : g_adr_wide
         assign adr_ext = {{(FE_ADDR_W-32){1'b0}}, DataAdr};
      end else if (FE_ADDR_W == 32) begin : g_adr_same
         assign adr_ext = DataAdr;
      end else begin : g_adr_narrow
         assign adr_ext = DataAdr[FE_ADDR_W-1:0];
      end
   endgenerate

   // Address 0 is never a data target, so a non-zero address or a store means an access
   assign req = MemWrite | (DataAdr != 32'd0);

   // Next-state and output computation; launching a new access is shared by IDLE and DONE
   always_comb begin
      state_d = state;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      launch  = 1'b0;
      case (state)
         IDLE: begin
            if (req) launch = 1'b1;
         end
         REQ: begin
            if (iob_ready_i) begin
               state_d = DONE;
               valid_d = 1'b0;
               wstrb_d = '0;
               if (!wr_q) rdata_d = iob_rdata_i;
            end
         end
         DONE: begin
            // A still-presented identical access is never re-issued
            if (!req) begin
               state_d = IDLE;
            end else if ((adr_ext != addr_q) || (MemWrite != wr_q)) begin
               launch = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            wstrb_d = '0;
         end
      endcase
      if (launch) begin
         state_d = REQ;
         valid_d = 1'b1;
         addr_d  = adr_ext;
         wdata_d = WriteData;
         wstrb_d = {STRB_W{MemWrite}};
         wr_d    = MemWrite;
      end
   end

   // State and registered outputs; reset abandons any in-flight access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state   <= state_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   assign iob_valid_o = valid_q;
   assign iob_addr_o  = addr_q;
   assign iob_wdata_o = wdata_q;
   assign iob_wstrb_o = wstrb_q;
   assign ReadData    = rdata_q;

endmodule

// File: tb/tb_cpu_iob_bridge.sv
// Directed bench for cpu_iob_bridge: write, read, back-to-back, wait states, hold, mid-access reset.
module tb_cpu_iob_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        iob_ready_i;
   logic [31:0] iob_rdata_i;
   logic        iob_valid_o;
   logic [31:0] iob_addr_o;
   logic [31:0] iob_wdata_o;
   logic [3:0]  iob_wstrb_o;
   logic        MemWrite;
   logic [31:0] WriteData;
   logic [31:0] DataAdr;
   logic [31:0] ReadData;

   int vectors = 0;
   int miscompares = 0;

   cpu_iob_bridge #(.FE_ADDR_W(32), .FE_DATA_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .iob_ready_i (iob_ready_i),
      .iob_rdata_i (iob_rdata_i),
      .iob_valid_o (iob_valid_o),
      .iob_addr_o  (iob_addr_o),
      .iob_wdata_o (iob_wdata_o),
      .iob_wstrb_o (iob_wstrb_o),
      .MemWrite    (MemWrite),
      .WriteData   (WriteData),
      .DataAdr     (DataAdr),
      .ReadData    (ReadData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] st();
      logic [1:0] s;
      s = dut.state;
      return {30'd0, s};
   endfunction

   initial begin
      reset       = 1'b0;
      iob_ready_i = 1'b0;
      iob_rdata_i = 32'h0;
      MemWrite    = 1'b0;
      WriteData   = 32'h0;
      DataAdr     = 32'h0;

      // Reset
      step();
      step();
      reset = 1'b1;
      step();
      chk("rst_state", st(), 32'h0);
      chk("rst_valid", {31'd0, iob_valid_o}, 32'h0);
      chk("rst_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
      chk("rst_rdata", ReadData, 32'h0);
      chk("rst_addr",  iob_addr_o, 32'h0);

      // Write
      DataAdr = 32'h1000; WriteData = 32'hDEADBEEF; MemWrite = 1'b1;
      step();
      chk("wr_valid", {31'd0, iob_valid_o}, 32'h1);
      chk("wr_addr",  iob_addr_o, 32'h1000);
      chk("wr_wdata", iob_wdata_o, 32'hDEADBEEF);
      chk("wr_wstrb", {28'd0, iob_wstrb_o}, 32'hF);
      chk("wr_state", st(), 32'h1);
      iob_ready_i = 1'b1; iob_rdata_i = 32'h55555555;
      step();
      chk("wr_done_state", st(), 32'h2);
      chk("wr_done_valid", {31'd0, iob_valid_o}, 32'h0);
      chk("wr_done_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
      chk("wr_done_rdata", ReadData, 32'h0);
      chk("wr_done_addr",  iob_addr_o, 32'h1000);
      iob_ready_i = 1'b0; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
      step();
      chk("wr_idle_state", st(), 32'h0);

      // Read
      DataAdr = 32'h2000;
      step();
      chk("rd_valid", {31'd0, iob_valid_o}, 32'h1);
      chk("rd_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
      chk("rd_addr",  iob_addr_o, 32'h2000);
      chk("rd_state", st(), 32'h1);
      iob_ready_i = 1'b1; iob_rdata_i = 32'hCAFEBABE;
      step();
      chk("rd_rdata", ReadData, 32'hCAFEBABE);
      chk("rd_done_state", st(), 32'h2);
      chk("rd_done_valid", {31'd0, iob_valid_o}, 32'h0);
      iob_ready_i = 1'b0; iob_rdata_i = 32'h0;
      step();
      chk("rd_hold_state", st(), 32'h2);
      chk("rd_hold_valid", {31'd0, iob_valid_o}, 32'h0);
      DataAdr = 32'h0;
      step();
      chk("rd_idle_state", st(), 32'h0);

      // Back-to-back: write then read with a single idle cycle between valids
      DataAdr = 32'h3000; WriteData = 32'h12345678; MemWrite = 1'b1;
      step();
      chk("b2b_wr_valid", {31'd0, iob_valid_o}, 32'h1);
      chk("b2b_wr_addr",  iob_addr_o, 32'h3000);
      chk("b2b_wr_wstrb", {28'd0, iob_wstrb_o}, 32'hF);
      iob_ready_i = 1'b1;
      step();
      chk("b2b_wr_done",  st(), 32'h2);
      chk("b2b_wr_rdata", ReadData, 32'hCAFEBABE);
      iob_ready_i = 1'b0; DataAdr = 32'h4000; MemWrite = 1'b0; iob_rdata_i = 32'h87654321;
      step();
      chk("b2b_rd_state", st(), 32'h1);
      chk("b2b_rd_valid", {31'd0, iob_valid_o}, 32'h1);
      chk("b2b_rd_addr",  iob_addr_o, 32'h4000);
      chk("b2b_rd_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
      iob_ready_i = 1'b1;
      step();
      chk("b2b_rd_rdata", ReadData, 32'h87654321);
      chk("b2b_rd_done",  st(), 32'h2);
      iob_ready_i = 1'b0;

      // Wait states: address and data remain stable while CPU inputs wander
      DataAdr = 32'h5000; WriteData = 32'h0;
      step();
      chk("ws_launch_addr", iob_addr_o, 32'h5000);
      for (int i = 0; i < 5; i++) begin
         DataAdr = 32'h5004 + 32'(i) * 32'h4;
         WriteData = 32'hF0F0F0F0 ^ 32'(i);
         iob_rdata_i = 32'h11111111 * 32'(i + 1);
         step();
         chk("ws_valid", {31'd0, iob_valid_o}, 32'h1);
         chk("ws_addr",  iob_addr_o, 32'h5000);
         chk("ws_wstrb", {28'd0, iob_wstrb_o}, 32'h0);
      end
      DataAdr = 32'h5000; iob_ready_i = 1'b1; iob_rdata_i = 32'hA5A5A5A5;
      step();
      chk("ws_rdata", ReadData, 32'hA5A5A5A5);
      chk("ws_done",  st(), 32'h2);
      // Same access held, with ready/rdata noise that must be ignored outside REQ
      iob_ready_i = 1'b1; iob_rdata_i = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid", {31'd0, iob_valid_o}, 32'h0);
         chk("hold_state", st(), 32'h2);
         chk("hold_rdata", ReadData, 32'hA5A5A5A5);
      end
      iob_ready_i = 1'b0;
      DataAdr = 32'h0;
      step();
      chk("hold_idle", st(), 32'h0);

      // Reset in the middle of a request
      DataAdr = 32'h6000;
      step();
      chk("mid_valid_pre", {31'd0, iob_valid_o}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_valid", {31'd0, iob_valid_o}, 32'h0);
      chk("mid_state", st(), 32'h0);
      chk("mid_rdata", ReadData, 32'h0);
      chk("mid_addr",  iob_addr_o, 32'h0);
      iob_ready_i = 1'b1; iob_rdata_i = 32'h99999999;
      step();
      chk("mid_in_rst_rdata", ReadData, 32'h0);
      iob_ready_i = 1'b0; DataAdr = 32'h0;
      reset = 1'b1;
      step();
      chk("post_rst_state", st(), 32'h0);
      chk("post_rst_valid", {31'd0, iob_valid_o}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
